// File: rtl/pixel_fp_pkg.sv
// Shared types and constants for the pixel-to-float sequencer.
package pixel_fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

  // Width of a packed pixel of num_ch 8-bit channels.
  function automatic int pix_width(input int num_ch);
    return 8 * num_ch;
  endfunction

endpackage

// File: rtl/uint_to_float.sv
// Combinational uint8 -> fp32 converter producing u8/255 rounded to nearest.
module uint_to_float
  import pixel_fp_pkg::*;
(
  input  logic [7:0]  u8,
  output logic [31:0] fp
);

  // k/255 for 1 <= k <= 254. With p the leading-one position of k, the result
  // lies in [2^(p-8), 2^(p-7)), so the exponent comes straight from p and the
  // 24-bit significand is k*2^(31-p)/255. A quotient never lands exactly on .5
  // (255 is odd), so adding half the divisor gives round-to-nearest.
  function automatic logic [31:0] div255_to_fp32(input logic [7:0] k);
    logic [2:0]  msb;
    logic [47:0] num;
    logic [22:0] frac;
    logic [7:0]  expo;
    msb = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (k[b]) msb = 3'(b);
    end
    num  = {40'd0, k} << (6'd31 - {3'd0, msb});
    frac = 23'((num + 48'd127) / 48'd255);
    expo = 8'd119 + {5'd0, msb};
    return {1'b0, expo, frac};
  endfunction

  // Endpoints are exact; everything else goes through the rounding divide.
  always_comb begin
    if (u8 == 8'd0) begin
      fp = FP32_ZERO;
    end else if (u8 == 8'hFF) begin
      fp = FP32_ONE;
    end else begin
      fp = div255_to_fp32(u8);
    end
  end

endmodule

// File: rtl/pixel_fp_sequencer.sv
// Time-multiplexes one uint_to_float converter across the channels of a pixel
// and presents all channel results together behind a valid/ready handshake.
module pixel_fp_sequencer
  import pixel_fp_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic                         i_pix_valid,
  output logic                         o_pix_ready,
  input  logic [pix_width(NUM_CH)-1:0] i_pix_data,
  output logic                         o_fp_valid,
  input  logic                         i_fp_ready,
  output logic [32*NUM_CH-1:0]         o_fp_data,
  output logic                         o_busy,
  output logic [CNT_W-1:0]             o_pix_count
);

  state_t                       state, state_nxt;
  logic [1:0]                   ch_idx;
  logic                         ch_last;
  logic [pix_width(NUM_CH)-1:0] pix_p0;
  logic [7:0]                   conv_in;
  logic [31:0]                  conv_out;
  logic [NUM_CH-1:0][31:0]      slot_p1;
  logic [NUM_CH-1:0][31:0]      slot_nxt;
  logic [NUM_CH-1:0][31:0]      fp_data_p2;
  logic                         accept;
  logic                         deliver;

  assign ch_last   = (ch_idx == 2'(NUM_CH - 1));
  assign accept    = (state == IDLE) && i_pix_valid;
  assign deliver   = (state == OUT) && i_fp_ready;
  assign o_fp_data = fp_data_p2;

  // Channel select feeding the shared converter.
  always_comb begin
    conv_in = 8'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_idx == 2'(k)) conv_in = pix_p0[8*k +: 8];
    end
  end

  uint_to_float u_conv (
    .u8 (conv_in),
    .fp (conv_out)
  );

  // Result slots with the current channel's conversion merged in.
  always_comb begin
    slot_nxt = slot_p1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_idx == 2'(k)) slot_nxt[k] = conv_out;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    o_pix_ready = 1'b0;
    o_fp_valid  = 1'b0;
    o_busy      = 1'b1;
    case (state)
      IDLE: begin
        o_pix_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_pix_valid) state_nxt = CONV;
      end
      CONV: begin
        if (ch_last) state_nxt = OUT;
      end
      OUT: begin
        o_fp_valid = 1'b1;
        if (i_fp_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // p0: capture pixel; p1: per-channel slots; p2: delivered word, loaded only
  // when the last channel completes so the output never shows a partial pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_p0     <= '0;
      ch_idx     <= 2'd0;
      slot_p1    <= '0;
      fp_data_p2 <= '0;
    end else begin
      if (accept) begin
        pix_p0 <= i_pix_data;
        ch_idx <= 2'd0;
      end
      if (state == CONV) begin
        slot_p1 <= slot_nxt;
        ch_idx  <= ch_idx + 2'd1;
        if (ch_last) fp_data_p2 <= slot_nxt;
      end
    end
  end

  // Delivered-pixel counter; clear takes priority over a same-cycle delivery.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_count <= '0;
    end else if (i_clear) begin
      o_pix_count <= '0;
    end else if (deliver) begin
      o_pix_count <= o_pix_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_fp_sequencer.sv
// Directed + randomized bench for pixel_fp_sequencer with a real-arithmetic model.
module tb_pixel_fp_sequencer;

  localparam int NUM_CH = 3;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic        fp_valid;
  logic        fp_ready;
  logic [95:0] fp_data;
  logic        busy;
  logic [15:0] pix_count;

  logic        pix_ready_w;
  logic        fp_valid_w;
  logic [95:0] fp_data_w;
  logic        busy_w;
  logic [2:0]  count_w;

  int tests;
  int fails;
  int exp_cnt;

  pixel_fp_sequencer #(.NUM_CH(NUM_CH), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (clear),
    .i_pix_valid (pix_valid),
    .o_pix_ready (pix_ready),
    .i_pix_data  (pix_data),
    .o_fp_valid  (fp_valid),
    .i_fp_ready  (fp_ready),
    .o_fp_data   (fp_data),
    .o_busy      (busy),
    .o_pix_count (pix_count)
  );

  // Narrow-counter copy sharing all inputs, used to observe counter wrap.
  pixel_fp_sequencer #(.NUM_CH(NUM_CH), .CNT_W(3)) dut_w (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (clear),
    .i_pix_valid (pix_valid),
    .o_pix_ready (pix_ready_w),
    .i_pix_data  (pix_data),
    .o_fp_valid  (fp_valid_w),
    .i_fp_ready  (fp_ready),
    .o_fp_data   (fp_data_w),
    .o_busy      (busy_w),
    .o_pix_count (count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // channel/255 computed in double precision, then rounded to fp32 (nearest-even).
  function automatic logic [31:0] ref_fp(input logic [7:0] k);
    real         r;
    logic [63:0] b;
    logic [30:0] mag;
    int          e;
    if (k == 8'd0) return 32'h0;
    r   = real'(k) / 255.0;
    b   = $realtobits(r);
    e   = int'(b[62:52]) - 1023 + 127;
    mag = {e[7:0], b[51:29]};
    if (b[28] && ((b[27:0] != 28'd0) || b[29])) mag = mag + 31'd1;
    return {1'b0, mag};
  endfunction

  function automatic logic [95:0] ref_pix(input logic [23:0] p);
    return {ref_fp(p[23:16]), ref_fp(p[15:8]), ref_fp(p[7:0])};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_cnt"}, 96'(pix_count), 96'(exp_cnt[15:0]));
    chk({tag, "_cnt_w"}, 96'(count_w), 96'(exp_cnt[2:0]));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, 96'(pix_ready), 96'(1));
    chk({tag, "_vld"}, 96'(fp_valid), 96'(0));
    chk({tag, "_data"}, fp_data, 96'(0));
    chk({tag, "_busy"}, 96'(busy), 96'(0));
    chk({tag, "_cnt"}, 96'(pix_count), 96'(0));
    chk({tag, "_cnt_w"}, 96'(count_w), 96'(0));
  endtask

  // Push one pixel through, optionally stalling the output, optionally
  // asserting clear on the delivery edge.
  task automatic run_pixel(input logic [23:0] p, input int stall, input bit clr);
    int          n;
    logic [95:0] e;
    e = ref_pix(p);
    chk("acc_rdy", 96'(pix_ready), 96'(1));
    pix_valid = 1'b1;
    pix_data  = p;
    fp_ready  = 1'b0;
    tick();
    pix_data = 24'($urandom);
    chk("conv_rdy", 96'(pix_ready), 96'(0));
    n = 0;
    while (!fp_valid && n < 20) begin
      pix_valid = 1'($urandom);
      pix_data  = 24'($urandom);
      tick();
      n++;
    end
    chk("lat", 96'(n), 96'(NUM_CH));
    chk("out_data", fp_data, e);
    chk("out_rdy", 96'(pix_ready), 96'(0));
    chk("out_busy", 96'(busy), 96'(1));
    for (int i = 0; i < stall; i++) begin
      pix_valid = 1'($urandom);
      tick();
      chk("stall_vld", 96'(fp_valid), 96'(1));
      chk("stall_data", fp_data, e);
    end
    pix_valid = 1'b0;
    fp_ready  = 1'b1;
    clear     = clr;
    tick();
    fp_ready = 1'b0;
    clear    = 1'b0;
    if (clr) exp_cnt = 0;
    else exp_cnt++;
    chk("hs_vld", 96'(fp_valid), 96'(0));
    chk("hs_rdy", 96'(pix_ready), 96'(1));
    chk("hs_hold", fp_data, e);
    check_counts("hs");
  endtask

  logic [23:0] b2b [3];
  logic [23:0] exp_q [$];
  int          idx;
  int          got;
  int          last_acc;
  int          cyc;

  initial begin
    tests = 0; fails = 0; exp_cnt = 0;
    rst_n = 1'b0; clear = 1'b0; pix_valid = 1'b0; fp_ready = 1'b0; pix_data = '0;

    // Reset held with random inputs, then released.
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'($urandom);
      fp_ready  = 1'($urandom);
      clear     = 1'($urandom);
      pix_data  = 24'($urandom);
      tick();
      chk_reset("rst_hold");
    end
    pix_valid = 1'b0; fp_ready = 1'b0; clear = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_reset("rst_rel");

    // Single pixel with exact endpoints and a midpoint.
    run_pixel(24'hFF8000, 0, 1'b0);
    chk("t2_lit", fp_data, 96'h3F800000_3F008081_00000000);

    // Backpressure for 10 cycles.
    run_pixel(24'h010203, 10, 1'b0);
    chk("t3_lit", fp_data, 96'h3B808081_3C008081_3C40C0C1);

    // Output ready with nothing pending changes nothing.
    fp_ready = 1'b1;
    tick(); tick();
    fp_ready = 1'b0;
    chk("idle_rdy_vld", 96'(fp_valid), 96'(0));
    check_counts("idle_rdy");

    // Randomized pixels with random stalls.
    for (int i = 0; i < 4; i++) run_pixel(24'($urandom), int'($urandom_range(0, 3)), 1'b0);

    // Back-to-back with valid held high and junk data while busy.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_cnt = 0;
    check_counts("clr");
    b2b[0] = 24'h123456; b2b[1] = 24'hFEDCBA; b2b[2] = 24'h7F80FF;
    idx = 0; got = 0; last_acc = 0; cyc = 0;
    fp_ready = 1'b1; pix_valid = 1'b1;
    while (got < 3 && cyc < 60) begin
      if (pix_ready) begin
        if (idx < 3) begin
          pix_data = b2b[idx];
          exp_q.push_back(b2b[idx]);
          if (idx > 0) chk("b2b_gap", 96'(cyc - last_acc), 96'(NUM_CH + 2));
          last_acc = cyc;
          idx++;
        end else begin
          pix_valid = 1'b0;
        end
      end else begin
        pix_data = 24'($urandom);
      end
      if (fp_valid) begin
        if (exp_q.size() > 0) chk("b2b_data", fp_data, ref_pix(exp_q.pop_front()));
        got++;
        exp_cnt++;
      end
      tick();
      cyc++;
    end
    pix_valid = 1'b0; fp_ready = 1'b0;
    chk("b2b_got", 96'(got), 96'(3));
    chk("b2b_cnt3", 96'(pix_count), 96'(3));
    check_counts("b2b");

    // Asynchronous reset in the second conversion cycle.
    pix_valid = 1'b1;
    pix_data  = 24'hA5C37E;
    tick();
    pix_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
    chk_reset("rst_mid_rel");
    run_pixel(24'h000000, 0, 1'b0);
    chk("t5_zero", fp_data, 96'h0);
    chk("t5_cnt1", 96'(pix_count), 96'(1));

    // Clear colliding with a delivery at count 5.
    for (int i = 0; i < 4; i++) run_pixel(24'($urandom), 0, 1'b0);
    chk("t6_cnt5", 96'(pix_count), 96'(5));
    run_pixel(24'($urandom), 1, 1'b1);
    chk("t6_clr", 96'(pix_count), 96'(0));

    // Enough deliveries to wrap the narrow counter.
    for (int i = 0; i < 9; i++) run_pixel(24'($urandom), int'($urandom_range(0, 2)), 1'b0);
    chk("wrap_cnt_w", 96'(count_w), 96'(1));
    chk("wrap_cnt", 96'(pix_count), 96'(9));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
